// File: rtl/sd_dec_pkg.sv
// Shared constants for the sinc3 sigma-delta decimator: symbol encodings,
// CIC order and the output-width rule.
package sd_dec_pkg;

   localparam logic [1:0] SYM_ZERO = 2'b00;
   localparam logic [1:0] SYM_POS  = 2'b01;
   localparam logic [1:0] SYM_NEG  = 2'b10;
   localparam logic [1:0] SYM_ILL  = 2'b11;

   localparam int N = 3;

   // |dout| <= R^3 = 2^(3*LOG2R), so one bit of headroom plus sign suffices
   function automatic int out_w(input int log2r);
      return 3 * log2r + 2;
   endfunction

endpackage

// File: rtl/sd_cic_integrator.sv
// One CIC integrator stage: free-running modulo-2^W accumulator.
module sd_cic_integrator #(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] acc
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) acc <= '0;
      else       acc <= acc + din;
   end

endmodule

// File: rtl/sd_sinc3_decimator.sv
// Sinc3 (3rd-order CIC) decimator for the 2-bit ternary modulator stream.
// Optional macro SD_DEC_SYMCHK_EN adds the saturating illegal-symbol counter.
module sd_sinc3_decimator
   import sd_dec_pkg::*;
#(
   parameter  int LOG2R = 6,
   localparam int OUT_W = out_w(LOG2R)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       sd_in,
   output logic [OUT_W-1:0] dout,
   output logic             dout_valid
`ifdef SD_DEC_SYMCHK_EN
   ,
   output logic [15:0]      sym_err_cnt
`endif
);

   logic [OUT_W-1:0]        x;
   logic [N:0][OUT_W-1:0]   integ;
   logic [OUT_W-1:0]        d0_z, c1_z, c2_z;
   logic [OUT_W-1:0]        c1, c2, c3;
   logic [LOG2R-1:0]        cnt;
   logic                    dec_pt;

   // Illegal 2'b11 contributes nothing to the datapath
   always_comb begin
      x = '0;
      case (sd_in)
         SYM_POS: x = OUT_W'(1);
         SYM_NEG: x = '1;
         default: x = '0;
      endcase
   end

   assign integ[0] = x;

   for (genvar g = 0; g < N; g++) begin : g_int
      sd_cic_integrator #(.W(OUT_W)) u_int (
         .clk   (clk),
         .reset (reset),
         .din   (integ[g]),
         .acc   (integ[g+1])
      );
   end

   // Comb section runs at the decimated rate; wrap-around cancels out
   assign c1     = integ[N] - d0_z;
   assign c2     = c1 - c1_z;
   assign c3     = c2 - c2_z;
   assign dec_pt = (cnt == '1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         d0_z       <= '0;
         c1_z       <= '0;
         c2_z       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         cnt        <= cnt + LOG2R'(1);
         dout_valid <= dec_pt;
         if (dec_pt) begin
            d0_z <= integ[N];
            c1_z <= c1;
            c2_z <= c2;
            dout <= c3;
         end
      end
   end

`ifdef SD_DEC_SYMCHK_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sym_err_cnt <= '0;
      else if (sd_in == SYM_ILL && sym_err_cnt != 16'hFFFF)
         sym_err_cnt <= sym_err_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sd_sinc3_decimator.sv
// Directed-plus-random bench for sd_sinc3_decimator; expected samples come from
// a closed-form sinc3 model over the applied symbol history.
module tb_sd_sinc3_decimator;

   localparam int LOG2R = 6;
   localparam int R     = 1 << LOG2R;
   localparam int OUT_W = 3 * LOG2R + 2;
   localparam logic [OUT_W-1:0] POS_FULL = OUT_W'(262144);
   localparam logic [OUT_W-1:0] NEG_FULL = OUT_W'(-262144);

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       sd_in;
   logic [OUT_W-1:0] dout;
   logic             dout_valid;
`ifdef SD_DEC_SYMCHK_EN
   logic [15:0]      sym_err_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   int          xs[$];          // mapped input applied at each edge since reset
   bit          const_chk;
   logic [OUT_W-1:0] const_val;
   int          err_model;

   sd_sinc3_decimator #(.LOG2R(LOG2R)) dut (
      .clk        (clk),
      .reset      (reset),
      .sd_in      (sd_in),
      .dout       (dout),
      .dout_valid (dout_valid)
`ifdef SD_DEC_SYMCHK_EN
      ,
      .sym_err_cnt(sym_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // i3 after t edges: triple running sum == convolution with C(t-1-s, 2)
   function automatic longint i3_at(input int t);
      longint acc = 0;
      for (int s = 0; s < t; s++) begin
         longint j = t - 1 - s;
         acc += longint'(xs[s]) * (j * (j - 1) / 2);
      end
      return acc;
   endfunction

   // Pulse n samples i3 just before edge n*R; output is the 3rd difference
   function automatic logic [OUT_W-1:0] model_pulse(input int n);
      longint d[4];
      longint v;
      logic [63:0] vv;
      for (int k = 0; k < 4; k++)
         d[k] = (n - k <= 0) ? 0 : i3_at((n - k) * R - 1);
      v  = d[0] - 3 * d[1] + 3 * d[2] - d[3];
      vv = v;
      return vv[OUT_W-1:0];
   endfunction

   function automatic int map_sym(input logic [1:0] s);
      case (s)
         2'b01:   return 1;
         2'b10:   return -1;
         default: return 0;
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      xs.delete();
      err_model = 0;
      const_chk = 1'b0;
   endtask

   // Applies one symbol, clocks it in, then checks strobe and sample
   task automatic step(input logic [1:0] s);
      int t, n;
      sd_in = s;
      xs.push_back(map_sym(s));
      if (s == 2'b11 && err_model != 16'hFFFF) err_model++;
      @(posedge clk);
      #1;
      t = xs.size();
      chk("valid_timing", 32'(dout_valid), 32'((t % R) == 0));
      if (t % R == 0) begin
         n = t / R;
         chk("dout_model", 32'(dout), 32'(model_pulse(n)));
         if (const_chk && n >= 4) chk("dout_steady", 32'(dout), 32'(const_val));
      end
   endtask

   task automatic run_const(input logic [1:0] s, input int pulses, input logic [OUT_W-1:0] want);
      const_chk = 1'b1;
      const_val = want;
      for (int i = 0; i < pulses * R; i++) step(s);
      const_chk = 1'b0;
   endtask

   initial begin
      sd_in     = 2'b00;
      reset     = 1'b1;
      err_model = 0;
      const_chk = 1'b0;
      const_val = '0;
      @(posedge clk);
      #1;
      chk("reset_dout", 32'(dout), 32'd0);
      chk("reset_valid", 32'(dout_valid), 32'd0);
      do_reset();

      run_const(2'b01, 10, POS_FULL);

      do_reset();
      run_const(2'b10, 8, NEG_FULL);

      do_reset();
      const_chk = 1'b1;
      const_val = '0;
      for (int i = 0; i < 8 * R; i++) step((i % 2 == 0) ? 2'b01 : 2'b10);
      const_chk = 1'b0;

      for (int seg = 0; seg < 3; seg++) begin
         do_reset();
         for (int i = 0; i < 10 * R; i++) step(2'($urandom_range(0, 3)));
      end

      // Long +1 run: i3 wraps many times over 2^OUT_W
      do_reset();
      run_const(2'b01, 100, POS_FULL);

      // Asynchronous reset mid-frame with cnt at 37
      for (int i = 0; i < 37; i++) step(2'b01);
      chk("pre_reset_dout", 32'(dout), 32'(POS_FULL));
      #1;
      reset = 1'b1;
      #1;
      chk("async_rst_dout", 32'(dout), 32'd0);
      chk("async_rst_valid", 32'(dout_valid), 32'd0);
      #1;
      reset = 1'b0;
      xs.delete();
      err_model = 0;
      run_const(2'b01, 5, POS_FULL);

`ifdef SD_DEC_SYMCHK_EN
      do_reset();
      for (int i = 0; i < 8 * R; i++)
         step((i >= 5 * R + 10 && i < 5 * R + 15) ? 2'b11 : 2'b01);
      chk("sym_err_cnt", 32'(sym_err_cnt), 32'(err_model));
      chk("sym_err_five", 32'(sym_err_cnt), 32'd5);
      do_reset();
      #1;
      chk("sym_err_reset", 32'(sym_err_cnt), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
